// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse stream-mode packet decoder: assembles 3-byte packets into buttons and deltas,
// then integrates the deltas into a clamped screen cursor position.
module ps2_mouse_packet_decoder #(
    parameter int CLK_HZ     = 27000000,
    parameter int TIMEOUT_US = 2000,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int POS_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    output logic              pkt_valid,
    output logic [2:0]        btn,
    output logic signed [8:0] dx,
    output logic signed [8:0] dy,
    output logic              x_ovf,
    output logic              y_ovf,
    output logic [POS_W-1:0]  pos_x,
    output logic [POS_W-1:0]  pos_y,
    output logic              sync_err,
    output logic [1:0]        idx
);

    // 64-bit product: TIMEOUT_US * CLK_HZ overflows 32 bits at the default clock.
    localparam int TIMEOUT_CYC = int'((64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000);
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int CW          = POS_W + 2;

    localparam logic signed [CW-1:0] X_MAX = CW'(SCREEN_W - 1);
    localparam logic signed [CW-1:0] Y_MAX = CW'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2
    } state_t;

    state_t        state, state_next, state_eff;
    logic [TW-1:0] timer, timer_next;
    logic [7:0]    status_q, status_next;
    logic [7:0]    xbyte_q, xbyte_next;
    logic          pkt_fire;
    logic          sync_fire;
    logic          timed_out;

    logic signed [CW-1:0] ex, ey, nx, ny;
    logic [POS_W-1:0]     nx_clamped, ny_clamped;

    assign idx = state;

    always_comb begin
        state_next  = state;
        state_eff   = state;
        timer_next  = timer;
        status_next = status_q;
        xbyte_next  = xbyte_q;
        pkt_fire    = 1'b0;
        sync_fire   = 1'b0;
        timed_out   = (state != S_B0) && (timer == TW'(TIMEOUT_CYC));

        if (!enable) begin
            state_next = S_B0;
            timer_next = '0;
        end else if (rx_err) begin
            state_next = S_B0;
            timer_next = '0;
            sync_fire  = 1'b1;
        end else begin
            // A timeout resyncs first, so a byte arriving in the same cycle is judged as a status byte.
            if (timed_out) begin
                state_eff  = S_B0;
                state_next = S_B0;
                sync_fire  = 1'b1;
            end
            case (state_eff)
                S_B0: begin
                    timer_next = '0;
                    if (rx_valid) begin
                        if (rx_data[3]) begin
                            status_next = rx_data;
                            state_next  = S_B1;
                        end else begin
                            sync_fire = 1'b1;
                        end
                    end
                end
                S_B1: begin
                    if (rx_valid) begin
                        xbyte_next = rx_data;
                        state_next = S_B2;
                        timer_next = '0;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
                S_B2: begin
                    if (rx_valid) begin
                        pkt_fire   = 1'b1;
                        state_next = S_B0;
                        timer_next = '0;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
                default: begin
                    state_next = S_B0;
                    timer_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        ex = x_ovf ? '0 : {{(CW-9){dx[8]}}, dx};
        ey = y_ovf ? '0 : {{(CW-9){dy[8]}}, dy};
        nx = $signed({2'b00, pos_x}) + ex;
        // Mouse Y grows upward, screen Y grows downward.
        ny = $signed({2'b00, pos_y}) - ey;

        if (nx[CW-1])       nx_clamped = '0;
        else if (nx > X_MAX) nx_clamped = X_MAX[POS_W-1:0];
        else                nx_clamped = nx[POS_W-1:0];

        if (ny[CW-1])       ny_clamped = '0;
        else if (ny > Y_MAX) ny_clamped = Y_MAX[POS_W-1:0];
        else                ny_clamped = ny[POS_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_B0;
            timer     <= '0;
            status_q  <= '0;
            xbyte_q   <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            btn       <= '0;
            dx        <= '0;
            dy        <= '0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
            pos_x     <= POS_W'(SCREEN_W / 2);
            pos_y     <= POS_W'(SCREEN_H / 2);
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            status_q  <= status_next;
            xbyte_q   <= xbyte_next;
            pkt_valid <= pkt_fire;
            sync_err  <= sync_fire;
            if (pkt_fire) begin
                btn   <= status_q[2:0];
                dx    <= {status_q[4], xbyte_q};
                dy    <= {status_q[5], rx_data};
                x_ovf <= status_q[6];
                y_ovf <= status_q[7];
            end
            if (pkt_valid && enable) begin
                pos_x <= nx_clamped;
                pos_y <= ny_clamped;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Directed bench for the PS/2 mouse packet decoder: expected packets and cursor
// positions are queued as bytes are driven and compared when pkt_valid fires.
module tb_ps2_mouse_packet_decoder;

    localparam int CLK_HZ     = 100000;
    localparam int TIMEOUT_US = 2000;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int POS_W      = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_err;
    logic             pkt_valid;
    logic [2:0]       btn;
    logic [8:0]       dx;
    logic [8:0]       dy;
    logic             x_ovf;
    logic             y_ovf;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             sync_err;
    logic [1:0]       idx;

    typedef struct packed {
        logic [2:0] btn;
        logic [8:0] dx;
        logic [8:0] dy;
        logic       xo;
        logic       yo;
        logic [9:0] px;
        logic [9:0] py;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t cur;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   sync_cnt = 0;
    int   pkt_cnt  = 0;
    int   mx, my;
    int   s0, p0;
    logic chk_pos  = 1'b0;

    ps2_mouse_packet_decoder #(
        .CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .POS_W(POS_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .pkt_valid(pkt_valid), .btn(btn), .dx(dx), .dy(dy),
        .x_ovf(x_ovf), .y_ovf(y_ovf), .pos_x(pos_x), .pos_y(pos_y),
        .sync_err(sync_err), .idx(idx)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle($urandom_range(0, 3));
    endtask

    task automatic send_err();
        @(posedge clk);
        #1;
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        rx_err   = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic push_expected(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
        pkt_t e;
        int   ex, ey;
        e.btn = s[2:0];
        e.dx  = {s[4], x};
        e.dy  = {s[5], y};
        e.xo  = s[6];
        e.yo  = s[7];
        ex = s[6] ? 0 : (s[4] ? int'(x) - 256 : int'(x));
        ey = s[7] ? 0 : (s[5] ? int'(y) - 256 : int'(y));
        mx = clamp(mx + ex, SCREEN_W - 1);
        my = clamp(my - ey, SCREEN_H - 1);
        e.px = 10'(mx);
        e.py = 10'(my);
        exp_q.push_back(e);
    endtask

    task automatic send_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
        push_expected(s, x, y);
        send_byte(s);
        send_byte(x);
        send_byte(y);
        idle(4);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (sync_err) sync_cnt++;
        if (chk_pos) begin
            check("pos_x", 32'(pos_x), 32'(cur.px));
            check("pos_y", 32'(pos_y), 32'(cur.py));
            chk_pos = 1'b0;
        end
        if (pkt_valid) begin
            pkt_cnt++;
            if (exp_q.size() == 0) begin
                check("pkt_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                cur = exp_q.pop_front();
                check("btn", 32'(btn), 32'(cur.btn));
                check("dx", 32'(dx), 32'(cur.dx));
                check("dy", 32'(dy), 32'(cur.dy));
                check("x_ovf", 32'(x_ovf), 32'(cur.xo));
                check("y_ovf", 32'(y_ovf), 32'(cur.yo));
                chk_pos = 1'b1;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
        check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
        check({tag, "_btn"}, 32'(btn), 32'd0);
        check({tag, "_dx"}, 32'(dx), 32'd0);
        check({tag, "_dy"}, 32'(dy), 32'd0);
        check({tag, "_ovf"}, 32'({x_ovf, y_ovf}), 32'd0);
        check({tag, "_idx"}, 32'(idx), 32'd0);
        check({tag, "_pos_x"}, 32'(pos_x), 32'd320);
        check({tag, "_pos_y"}, 32'(pos_y), 32'd240);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
        mx = SCREEN_W / 2;
        my = SCREEN_H / 2;
        idle(3);
        @(negedge clk);
        check_reset_state("reset");
        #1;
        rst = 1'b0;
        enable = 1'b1;
        idle(2);

        // T1/T2: basic packets
        send_pkt(8'h29, 8'h05, 8'hFD);
        send_pkt(8'h08, 8'h0A, 8'h08);
        check("t12_no_sync", 32'(sync_cnt), 32'd0);

        // T3: repeated -256 in x saturates at 0
        repeat (3) send_pkt(8'h18, 8'h00, 8'h08);

        // T4: bad status byte, then resync
        s0 = sync_cnt; p0 = pkt_cnt;
        send_byte(8'h05);
        idle(3);
        check("t4_sync", 32'(sync_cnt - s0), 32'd1);
        check("t4_no_pkt", 32'(pkt_cnt - p0), 32'd0);
        send_pkt(8'h09, 8'h01, 8'h00);

        // T5: inter-byte timeout
        s0 = sync_cnt; p0 = pkt_cnt;
        send_byte(8'h09);
        send_byte(8'h05);
        idle(300);
        send_pkt(8'h08, 8'h0A, 8'h08);
        check("t5_sync", 32'(sync_cnt - s0), 32'd1);
        check("t5_pkt", 32'(pkt_cnt - p0), 32'd1);

        // T6a: receive error on byte 1
        s0 = sync_cnt; p0 = pkt_cnt;
        send_byte(8'h09);
        send_err();
        idle(3);
        check("t6a_sync", 32'(sync_cnt - s0), 32'd1);
        check("t6a_idx", 32'(idx), 32'd0);
        send_pkt(8'h08, 8'h01, 8'h00);
        check("t6a_pkt", 32'(pkt_cnt - p0), 32'd1);

        // T6b: reset mid-packet
        send_byte(8'h09);
        send_byte(8'h05);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        mx = SCREEN_W / 2;
        my = SCREEN_H / 2;
        send_pkt(8'h08, 8'h02, 8'h00);

        // T6c: enable low forces idle and ignores bytes
        send_byte(8'h09);
        check("t6c_idx_b1", 32'(idx), 32'd1);
        enable = 1'b0;
        idle(2);
        check("t6c_idx_forced", 32'(idx), 32'd0);
        s0 = sync_cnt; p0 = pkt_cnt;
        send_byte(8'h09);
        send_byte(8'h05);
        send_byte(8'hFD);
        send_byte(8'h05);
        send_err();
        idle(3);
        check("t6c_no_pkt", 32'(pkt_cnt - p0), 32'd0);
        check("t6c_no_sync", 32'(sync_cnt - s0), 32'd0);
        check("t6c_pos_x", 32'(pos_x), 32'd322);
        enable = 1'b1;
        idle(2);
        send_pkt(8'h08, 8'h03, 8'h00);

        // T6d: overflow packets keep pos, still strobe
        send_pkt(8'h48, 8'h7F, 8'h00);
        send_pkt(8'h88, 8'h00, 8'h50);

        // Upper clamps in x and y
        send_pkt(8'h08, 8'hFF, 8'h00);
        send_pkt(8'h08, 8'hFF, 8'h00);
        send_pkt(8'h28, 8'h00, 8'h00);
        send_pkt(8'h0F, 8'h00, 8'h00);

        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
